sram_req_rsp_mem: RTL and testbench
===================================

Name: sram_req_rsp_mem

Overview:
Parametrised single-port word-addressed SRAM model with the core's valid/addr/data/byte-lane/isWrite request bundle. It generalises the fixed data/instruction memories: configurable width, depth, base address and read latency, pipelined multiple-outstanding requests with ready/valid backpressure on both channels, and an error response for out-of-range, misaligned or read-only-write accesses. It instantiates as the core's dmem, and as imem with READ_ONLY=1.

Parameters:
DATA_W, 32, data width in bits; multiple of 8, power of two.
ADDR_W, 32, byte-address width.
DEPTH, 1024, number of DATA_W words; power of two.
LATENCY, 1, cycles from request acceptance to earliest io_rsp_valid; legal 1..4.
BASE_ADDR, 0, byte address of word 0.
READ_ONLY, 0, 1 = writes are rejected with error.

Ports:
clock  in  1  clock.
reset  in  1  reset.
io_req_valid  in  1  request valid.
io_req_ready  out  1  request accepted when valid && ready.
io_req_bits_addrRequest  in  ADDR_W  byte address.
io_req_bits_dataRequest  in  DATA_W  write data.
io_req_bits_activeByteLane  in  DATA_W/8  write byte enables.
io_req_bits_isWrite  in  1  1 = write, 0 = read.
io_rsp_valid  out  1  response valid.
io_rsp_ready  in  1  response consumed when valid && ready.
io_rsp_bits_dataResponse  out  DATA_W  read data; 0 for writes and errors.
io_rsp_bits_error  out  1  access error.

Behaviour:
- One clock, clock. reset is asynchronous, active-high. While reset is asserted: io_rsp_valid=0, io_rsp_bits_dataResponse=0, io_rsp_bits_error=0, io_req_ready=0. io_req_ready rises on the first clock edge after deassertion. Array contents are not reset.
- Reset mid-operation: all in-flight and buffered responses are discarded. No partial write occurs; a write is committed only on its acceptance edge.
- Decode: off = addr - BASE_ADDR (ADDR_W modular arithmetic); idx = off >> log2(DATA_W/8).
  - Error if any of: off[log2(DATA_W/8)-1:0] != 0 (misaligned); idx >= DEPTH (this includes addr < BASE_ADDR through wrap); isWrite && READ_ONLY.
  - An erroring access never modifies the array.
- Write: on the acceptance edge, byte lane b of word idx is updated iff activeByteLane[b]. A zero byte-lane mask is a legal no-op write with error=0.
- Read: the array is read on the acceptance edge, so it returns data including all earlier-accepted writes. The value travels through LATENCY-1 delay stages.
- Every accepted request, read or write, produces exactly one response, in order.
- Response timing: earliest io_rsp_valid is LATENCY cycles after the acceptance edge. Back-to-back requests give back-to-back responses when io_rsp_ready=1.
- Buffering: responses enter a FIFO of depth LATENCY+1. outstanding = in-pipeline + in-FIFO.
  - io_req_ready = (outstanding < LATENCY+1), registered.
  - A response popped in the same cycle frees a slot for the next cycle, not the current one.
  - With io_rsp_ready held low, the block accepts exactly LATENCY+1 requests and then stalls with no loss or duplication.
- Response stability: io_rsp_valid and its payload hold stable until consumed.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Throughput: 1 request/cycle sustained when io_rsp_ready=1.

Decomposition:
- Package mem_pkg holds:
  - typedef mem_rsp_t {data, error}
  - function clog2-based byte-offset width
  - localparams for the LATENCY limits
- The response buffer is a natural sub-module: sync_fifo (parameters WIDTH, DEPTH; async active-high reset on clock/reset).
- Array, decode and delay line stay in the top.

Test Plan:
- Reset, then write addr 0x10, data 0xDEADBEEF, lanes 4'b1111; read 0x10 (LATENCY=1) -> write rsp data 0, error 0; read rsp 0xDEADBEEF one cycle after acceptance.
- Write 0x10 lanes 4'b0101, data 0x11223344 over 0xDEADBEEF; read 0x10 -> 0xDE22BE44.
- Read 0x13 (misaligned), and read 0x1000 with DEPTH=1024 -> error=1, data 0. A following read of 0x0 returns unchanged contents.
- LATENCY=3, io_rsp_ready=0, 6 back-to-back reads of 0x0,0x4,... -> exactly 4 accepted, io_req_ready=0. Release ready -> 4 in-order responses, then remaining 2 accepted.
- READ_ONLY=1, write 0x8 data 0xFFFFFFFF -> error=1; read 0x8 returns the prior value.
- Assert reset with 3 responses outstanding -> io_rsp_valid=0 immediately. After release, no stale responses appear and io_req_ready=1 one edge later.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the request/response SRAM model.
// Used by the memory top and by anything that talks to it.
package mem_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam int CORE_DATA_W = 32;

  typedef struct packed {
    logic [CORE_DATA_W-1:0] data;
    logic                   error;
  } mem_rsp_t;

  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small circular FIFO, first word visible at the output.
// Push on a full FIFO is only taken together with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop && (cnt != '0);
  assign do_push  = push && ((cnt != CW'(DEPTH)) || do_pop);
  assign valid    = (cnt != '0);
  assign pop_data = mem[rp];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/sram_req_rsp_mem.sv
// Single-port word SRAM with pipelined valid/ready request and
// response channels, fixed read latency and access error checks.
module sram_req_rsp_mem
  import mem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                READ_ONLY = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic [ADDR_W-1:0]   io_req_bits_addrRequest,
  input  logic [DATA_W-1:0]   io_req_bits_dataRequest,
  input  logic [DATA_W/8-1:0] io_req_bits_activeByteLane,
  input  logic                io_req_bits_isWrite,
  output logic                io_rsp_valid,
  input  logic                io_rsp_ready,
  output logic [DATA_W-1:0]   io_rsp_bits_dataResponse,
  output logic                io_rsp_bits_error
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = byte_off_w(DATA_W);
  localparam int IW   = $clog2(DEPTH);
  localparam int LAT  = (LATENCY < LAT_MIN) ? LAT_MIN :
                        (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
  localparam int CAP  = LAT + 1;
  localparam int OW   = $clog2(CAP + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              error;
  } rsp_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;
  logic              err;
  logic              acc;
  logic              pop;
  logic              push;
  rsp_t              rd_rsp;
  rsp_t              push_rsp;
  rsp_t              head;
  logic              fifo_valid;
  logic [OW-1:0]     outs;
  logic [OW-1:0]     outs_nxt;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign off = io_req_bits_addrRequest - BASE_ADDR;
  assign idx = off >> OFFW;
  assign err = ((off & ADDR_W'(NB - 1)) != '0)
            || (idx >= ADDR_W'(DEPTH))
            || (io_req_bits_isWrite && READ_ONLY);

  assign acc = io_req_valid && io_req_ready;
  assign pop = io_rsp_valid && io_rsp_ready;

  assign rd_rsp.data  = (io_req_bits_isWrite || err) ? '0
                        : mem[idx[IW-1:0]];
  assign rd_rsp.error = err;

  always_ff @(posedge clock) begin
    if (acc && !err && io_req_bits_isWrite) begin
      for (int b = 0; b < NB; b++) begin
        if (io_req_bits_activeByteLane[b])
          mem[idx[IW-1:0]][b*8 +: 8] <= io_req_bits_dataRequest[b*8 +: 8];
      end
    end
  end

  generate
    if (LAT == 1) begin : g_direct
      assign push     = acc;
      assign push_rsp = rd_rsp;
    end else begin : g_pipe
      logic [LAT-2:0] pv;
      rsp_t           pd [LAT-1];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pv <= '0;
          for (int i = 0; i < LAT - 1; i++) pd[i] <= '0;
        end else begin
          pv[0] <= acc;
          pd[0] <= rd_rsp;
          for (int i = 1; i < LAT - 1; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign push     = pv[LAT-2];
      assign push_rsp = pd[LAT-2];
    end
  endgenerate

  sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (CAP)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_rsp),
    .pop       (pop),
    .pop_data  (head),
    .valid     (fifo_valid)
  );

  assign io_rsp_valid             = fifo_valid;
  assign io_rsp_bits_dataResponse = fifo_valid ? head.data : '0;
  assign io_rsp_bits_error        = fifo_valid && head.error;

  // Credit count covers the pipeline and the FIFO, so the FIFO never overflows.
  assign outs_nxt = outs + OW'(acc) - OW'(pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outs         <= '0;
      io_req_ready <= 1'b0;
    end else begin
      outs         <= outs_nxt;
      io_req_ready <= (outs_nxt < OW'(CAP));
    end
  end

endmodule

// File: tb/tb_sram_req_rsp_mem.sv
// Bench for sram_req_rsp_mem: directed vectors, backpressure,
// read-only, reset flush and randomized traffic vs a model.
module tb_sram_req_rsp_mem;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rv [3];
  logic        rr [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [3:0]  be [3];
  logic        wr [3];
  logic        sv [3];
  logic        sr [3];
  logic [31:0] sd [3];
  logic        se [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_req_rsp_mem #(
      .DATA_W    (32),
      .ADDR_W    (32),
      .DEPTH     (1024),
      .LATENCY   (g == 0 ? 1 : g == 1 ? 3 : 2),
      .BASE_ADDR (g == 2 ? 32'h100 : 32'h0),
      .READ_ONLY (g == 2)
    ) u (
      .clock                      (clk),
      .reset                      (rst),
      .io_req_valid               (rv[g]),
      .io_req_ready               (rr[g]),
      .io_req_bits_addrRequest    (ad[g]),
      .io_req_bits_dataRequest    (wd[g]),
      .io_req_bits_activeByteLane (be[g]),
      .io_req_bits_isWrite        (wr[g]),
      .io_rsp_valid               (sv[g]),
      .io_rsp_ready               (sr[g]),
      .io_rsp_bits_dataResponse   (sd[g]),
      .io_rsp_bits_error          (se[g])
    );
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step(input int k, output logic acc, output logic pop,
                      output logic [31:0] pd, output logic pe);
    acc = rv[k] && rr[k];
    pop = sv[k] && sr[k];
    pd  = sd[k];
    pe  = se[k];
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] dd, input logic [3:0] b,
                      output logic [31:0] d, output logic e,
                      output int lat);
    logic acc, pop, pe;
    logic [31:0] pd;
    bit done;
    rv[k] = 1'b1; wr[k] = w; ad[k] = a; wd[k] = dd; be[k] = b;
    sr[k] = 1'b1;
    d = 'x; e = 'x; lat = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step(k, acc, pop, pd, pe);
      done = acc;
    end
    rv[k] = 1'b0;
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL xact_accept: got timeout expected accept addr %0h", a);
    end
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step(k, acc, pop, pd, pe);
      lat++;
      if (pop) begin
        d = pd; e = pe; done = 1;
      end
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL xact_rsp: got timeout expected response addr %0h", a);
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    mem_rsp_t    exp;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b,
                              input logic [31:0] ed, input logic ee);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.b = b;
    v.exp.data = ed; v.exp.error = ee;
    return v;
  endfunction

  vec_t        tv [$];
  logic [31:0] m  [16];
  mem_rsp_t    q  [$];
  logic [31:0] got [$];

  initial begin
    logic [31:0] d, d0, pd;
    logic        e, acc, pop, pe;
    int          lat, n_acc, n_pop;
    mem_rsp_t    ex;

    for (int k = 0; k < 3; k++) begin
      rv[k] = 0; ad[k] = 0; wd[k] = 0; be[k] = 0; wr[k] = 0; sr[k] = 0;
    end

    // reset state
    #1;
    chk("rst_ready", rr[0], 0);
    chk("rst_valid", sv[0], 0);
    chk("rst_data", sd[0], 0);
    chk("rst_error", se[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready_held", rr[0], 0);
    @(posedge clk);
    #1;
    chk("ready_after_rst0", rr[0], 1);
    chk("ready_after_rst1", rr[1], 1);

    // directed vectors on the LATENCY=1 instance
    tv.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0));
    tv.push_back(mk(0, 32'h10, 0, 0, 32'hDEADBEEF, 0));
    tv.push_back(mk(1, 32'h10, 32'h11223344, 4'b0101, 0, 0));
    tv.push_back(mk(0, 32'h10, 0, 0, 32'hDE22BE44, 0));
    tv.push_back(mk(1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0));
    tv.push_back(mk(0, 32'h13, 0, 0, 0, 1));
    tv.push_back(mk(0, 32'h1000, 0, 0, 0, 1));
    tv.push_back(mk(1, 32'h1000, 32'h55555555, 4'hF, 0, 1));
    tv.push_back(mk(1, 32'h2, 32'h66666666, 4'hF, 0, 1));
    tv.push_back(mk(0, 32'h0, 0, 0, 32'hCAFEF00D, 0));
    tv.push_back(mk(1, 32'hFFC, 32'h12345678, 4'hF, 0, 0));
    tv.push_back(mk(0, 32'hFFC, 0, 0, 32'h12345678, 0));
    tv.push_back(mk(1, 32'h0, 32'hFFFFFFFF, 4'h0, 0, 0));
    tv.push_back(mk(0, 32'h0, 0, 0, 32'hCAFEF00D, 0));
    tv.push_back(mk(1, 32'h4, 32'hAABBCCDD, 4'b1000, 0, 0));
    foreach (tv[i]) begin
      xact(0, tv[i].w, tv[i].a, tv[i].d, tv[i].b, d, e, lat);
      chk($sformatf("vec%0d_data", i), d, tv[i].exp.data);
      chk($sformatf("vec%0d_err", i), e, tv[i].exp.error);
      chk($sformatf("vec%0d_lat", i), lat, 1);
    end

    // backpressure on the LATENCY=3 instance
    for (int i = 0; i < 6; i++) begin
      xact(1, 1, i * 4, 32'hA0000000 + i, 4'hF, d, e, lat);
      if (i == 0) chk("l3_write_lat", lat, 3);
    end
    xact(1, 0, 32'h0, 0, 0, d, e, lat);
    chk("l3_read_lat", lat, 3);
    chk("l3_read_data", d, 32'hA0000000);
    sr[1] = 0; wr[1] = 0; n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      rv[1] = (n_acc < 6);
      ad[1] = n_acc * 4;
      step(1, acc, pop, pd, pe);
      if (acc) n_acc++;
    end
    chk("bp_accepted", n_acc, 4);
    chk("bp_ready_low", rr[1], 0);
    chk("bp_valid_held", sv[1], 1);
    sr[1] = 1;
    got.delete();
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      rv[1] = (n_acc < 6);
      ad[1] = n_acc * 4;
      step(1, acc, pop, pd, pe);
      if (acc) n_acc++;
      if (pop) begin
        got.push_back(pd);
        chk("bp_rsp_err", pe, 0);
      end
    end
    rv[1] = 0;
    chk("bp_total_acc", n_acc, 6);
    chk("bp_total_rsp", got.size(), 6);
    foreach (got[i]) chk($sformatf("bp_order%0d", i), got[i], 32'hA0000000 + i);

    // read-only instance, base 0x100
    xact(2, 0, 32'h108, 0, 0, d0, e, lat);
    chk("ro_read_err", e, 0);
    chk("ro_read_lat", lat, 2);
    xact(2, 1, 32'h108, 32'hFFFFFFFF, 4'hF, d, e, lat);
    chk("ro_write_err", e, 1);
    chk("ro_write_data", d, 0);
    xact(2, 0, 32'h108, 0, 0, d, e, lat);
    chk("ro_unchanged", d, d0);
    xact(2, 0, 32'hFC, 0, 0, d, e, lat);
    chk("ro_below_base", e, 1);
    chk("ro_below_data", d, 0);
    xact(2, 0, 32'h1100, 0, 0, d, e, lat);
    chk("ro_above_top", e, 1);

    // randomized traffic on the LATENCY=1 instance against a model
    for (int i = 0; i < 16; i++) begin
      m[i] = $urandom;
      xact(0, 1, i * 4, m[i], 4'hF, d, e, lat);
      chk("fill_err", e, 0);
    end
    q.delete();
    for (int c = 0; c < 400; c++) begin
      int w, sel;
      w   = $urandom_range(0, 15);
      sel = $urandom_range(0, 9);
      rv[0] = ($urandom_range(0, 9) < 7);
      wr[0] = $urandom_range(0, 1);
      ad[0] = (sel == 0) ? w * 4 + $urandom_range(1, 3)
            : (sel == 1) ? 32'h1000 + w * 4 : w * 4;
      wd[0] = $urandom;
      be[0] = 4'($urandom);
      sr[0] = ($urandom_range(0, 3) != 0);
      step(0, acc, pop, pd, pe);
      if (pop) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rnd_extra: got response expected none");
        end else begin
          ex = q.pop_front();
          chk("rnd_data", pd, ex.data);
          chk("rnd_err", pe, ex.error);
        end
      end
      if (acc) begin
        logic err;
        int   idx;
        idx = int'(ad[0] >> 2);
        err = (ad[0] % 4 != 0) || (idx >= 1024);
        if (!err && wr[0])
          for (int b = 0; b < 4; b++)
            if (be[0][b]) m[idx][b*8 +: 8] = wd[0][b*8 +: 8];
        ex.error = err;
        ex.data  = (err || wr[0]) ? 32'h0 : m[idx];
        q.push_back(ex);
      end
      chk("rnd_valid", sv[0], q.size() != 0);
      chk("rnd_ready", rr[0], q.size() < 2);
    end
    rv[0] = 0; sr[0] = 1;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      step(0, acc, pop, pd, pe);
      if (pop) begin
        ex = q.pop_front();
        chk("drain_data", pd, ex.data);
        chk("drain_err", pe, ex.error);
      end
    end
    chk("drain_empty", q.size(), 0);

    // reset with responses outstanding on the LATENCY=3 instance
    sr[1] = 0; wr[1] = 0; n_acc = 0;
    for (int c = 0; c < 10 && n_acc < 3; c++) begin
      rv[1] = 1;
      ad[1] = n_acc * 4;
      step(1, acc, pop, pd, pe);
      if (acc) n_acc++;
    end
    rv[1] = 0;
    repeat (4) step(1, acc, pop, pd, pe);
    chk("pre_rst_valid", sv[1], 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", sv[1], 0);
    chk("mid_rst_ready", rr[1], 0);
    chk("mid_rst_data", sd[1], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_ready0", rr[1], 0);
    @(posedge clk);
    #1;
    chk("post_rst_ready1", rr[1], 1);
    sr[1] = 1; n_pop = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, acc, pop, pd, pe);
      if (pop) n_pop++;
    end
    chk("no_stale_rsp", n_pop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
